// File: rtl/count_display_driver_if.sv
// Bundle of the value/BCD/display signals between the counter stage,
// the BCD display driver and whatever observes the converted result.
interface count_display_driver_if #(
    parameter int Nbits = 4
);
    logic [Nbits-1:0] value;
    logic [15:0]      bcd;
    logic             conv_done;
    logic             busy;
    logic [6:0]       seg;
    logic [3:0]       an;

    modport master (
        output value,
        input  bcd, conv_done, busy, seg, an
    );

    modport slave (
        input  value,
        output bcd, conv_done, busy, seg, an
    );
endinterface

// File: rtl/count_display_driver.sv
// Free-running binary-to-BCD converter (double-dabble, one bit per cycle)
// driving a multiplexed common-anode 4-digit 7-segment display.
//
// state | meaning
// IDLE  | capture value, clear working register (1 cycle)
// SHIFT | add-3 on nibbles >= 5, then shift left (Nbits cycles)
// DONE  | publish working register to bcd, pulse conv_done (1 cycle)
module count_display_driver #(
    parameter int Nbits    = 4,
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    count_display_driver_if.slave bus
);

    localparam int CW = (Nbits > 1) ? $clog2(Nbits) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [Nbits-1:0] sr_q;
    logic [15:0]      work_q;
    logic [15:0]      work_adj;
    logic [CW-1:0]    cnt_q;
    logic [15:0]      bcd_q;
    logic             done_q;
    logic             busy_q;

    logic [PW-1:0]    pre_q;
    logic [1:0]       idx_q;
    logic             fresh_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;

    logic             wrap;
    logic [1:0]       idx_ld;
    logic [3:0]       digit_ld;
    logic             blank_ld;
    logic [6:0]       seg_ld;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with registered bcd, conv_done and busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sr_q    <= bus.value;
                    work_q  <= '0;
                    cnt_q   <= CW'(Nbits - 1);
                    busy_q  <= 1'b1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    {work_q, sr_q} <= {work_adj, sr_q} << 1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    bcd_q   <= work_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slot boundary decode: the first edge after reset opens slot 0 without
    // advancing, later slots open when the prescaler wraps.
    always_comb begin
        wrap     = (pre_q == PW'(SCAN_DIV - 1));
        idx_ld   = fresh_q ? idx_q : idx_q + 2'd1;
        digit_ld = bcd_q[{idx_ld, 2'b00} +: 4];
        case (idx_ld)
            2'd1:    blank_ld = (bcd_q[15:4] == 12'h000);
            2'd2:    blank_ld = (bcd_q[15:8] == 8'h00);
            2'd3:    blank_ld = (bcd_q[15:12] == 4'h0);
            default: blank_ld = 1'b0;
        endcase
        seg_ld = (BLANK && blank_ld) ? 7'h7F : seg_decode(digit_ld);
    end

    // Digit scan: prescaler, digit index and registered an/seg.
    // The prescaler holds on the slot-0 opening edge so that slot lasts SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            fresh_q <= 1'b1;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            fresh_q <= 1'b0;
            if (fresh_q || wrap) begin
                idx_q <= idx_ld;
                an_q  <= ~(4'b0001 << idx_ld);
                seg_q <= seg_ld;
            end
            if (!fresh_q) begin
                pre_q <= wrap ? '0 : pre_q + PW'(1);
            end
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.conv_done = done_q;
    assign bus.busy      = busy_q;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomised bench for count_display_driver: three configurations driven in
// lock-step and compared every cycle against a decimal-arithmetic model.
module tb_count_display_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    count_display_driver_if #(.Nbits(4))  if0 ();
    count_display_driver_if #(.Nbits(13)) if1 ();
    count_display_driver_if #(.Nbits(13)) if2 ();

    count_display_driver #(.Nbits(4), .SCAN_DIV(3), .BLANK(1'b1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );
    count_display_driver #(.Nbits(13), .SCAN_DIV(4), .BLANK(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );
    count_display_driver #(.Nbits(13), .SCAN_DIV(4), .BLANK(1'b0)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    int nb[3] = '{4, 13, 13};
    int sd[3] = '{3, 4, 4};
    int bl[3] = '{1, 1, 0};
    int seg_tab[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    // model state: t = clock edges seen since reset release
    int t_m[3], samp_m[3], dec_m[3], done_m[3], busy_m[3], seg_m[3], an_m[3];
    int m_val, m_per, m_idx;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int to_bcd(input int dec);
        int r = 0;
        for (int i = 0; i < 4; i++) r = r | (((dec / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    function automatic int seg_exp(input int dec, input int idx, input int blank);
        if (blank != 0 && idx > 0 && dec < pow10(idx)) return 'h7F;
        return seg_tab[(dec / pow10(idx)) % 10];
    endfunction

    // Reference: a conversion period of Nbits+2 edges samples value on its
    // first edge and publishes on its last; a digit slot opens every SCAN_DIV edges.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                t_m[k] = 0; samp_m[k] = 0; dec_m[k] = 0; done_m[k] = 0;
                busy_m[k] = 0; seg_m[k] = 'h7F; an_m[k] = 'hF;
            end else begin
                m_val = (k == 0) ? int'(if0.value) : int'(if1.value);
                m_per = nb[k] + 2;
                if (t_m[k] % sd[k] == 0) begin
                    m_idx = (t_m[k] / sd[k]) % 4;
                    an_m[k]  = 'hF ^ (1 << m_idx);
                    seg_m[k] = seg_exp(dec_m[k], m_idx, bl[k]);
                end
                if (t_m[k] % m_per == 0) samp_m[k] = m_val;
                done_m[k] = (t_m[k] % m_per == m_per - 1) ? 1 : 0;
                if (done_m[k] != 0) dec_m[k] = samp_m[k];
                busy_m[k] = (done_m[k] != 0) ? 0 : 1;
                t_m[k]++;
            end
        end
    end

    int o_bcd, o_done, o_busy, o_seg, o_an;

    // Compare every DUT output against the model away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: begin o_bcd = int'(if0.bcd); o_done = int'(if0.conv_done); o_busy = int'(if0.busy);
                             o_seg = int'(if0.seg); o_an = int'(if0.an); end
                    1: begin o_bcd = int'(if1.bcd); o_done = int'(if1.conv_done); o_busy = int'(if1.busy);
                             o_seg = int'(if1.seg); o_an = int'(if1.an); end
                    default: begin o_bcd = int'(if2.bcd); o_done = int'(if2.conv_done); o_busy = int'(if2.busy);
                             o_seg = int'(if2.seg); o_an = int'(if2.an); end
                endcase
                check_eq($sformatf("dut%0d.bcd", k),       o_bcd,  to_bcd(dec_m[k]));
                check_eq($sformatf("dut%0d.conv_done", k), o_done, done_m[k]);
                check_eq($sformatf("dut%0d.busy", k),      o_busy, busy_m[k]);
                check_eq($sformatf("dut%0d.seg", k),       o_seg,  seg_m[k]);
                check_eq($sformatf("dut%0d.an", k),        o_an,   an_m[k]);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_vals(input int v4, input int v13);
        if0.value = 4'(v4);
        if1.value = 13'(v13);
        if2.value = 13'(v13);
    endtask

    initial begin
        set_vals(0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        run(2);

        // constant 11 / 8191, then 0, then 7 for blanking
        set_vals('hB, 8191);
        rst = 1'b1;
        run(48);
        set_vals('hB, 0);
        run(20);
        set_vals(5, 7);
        run(48);

        // reset during the third SHIFT cycle
        set_vals(9, 9);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        run(40);

        // random values, random hold times, occasional reset pulses
        for (int i = 0; i < 60; i++) begin
            set_vals($urandom_range(0, 15), $urandom_range(0, 8191));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b0;
                run($urandom_range(1, 3));
                rst = 1'b1;
            end
            run($urandom_range(1, 30));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
